// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: stage counting, padding,
// operand extension and overflow detection.
package adder_tree_pkg;

  localparam int MAX_W = 64;

  function automatic int stage_cnt(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int padded_cnt(input int n);
    return 1 << stage_cnt(n);
  endfunction

  // Bit b of v (w meaningful bits) after sign- or zero-extension.
  function automatic logic extend_bit(input logic [MAX_W-1:0] v, input int w,
                                      input int b, input bit is_signed);
    if (b < w) return v[b];
    return is_signed & v[w-1];
  endfunction

  function automatic logic add_overflow(input bit is_signed, input logic a_msb,
                                        input logic b_msb, input logic s_msb,
                                        input logic carry);
    if (is_signed) return (a_msb == b_msb) && (s_msb != a_msb);
    return carry;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise-add level of the reduction tree; each output is one
// bit wider than its inputs so the tree itself can never overflow.
module adder_tree_level #(
  parameter int N      = 2,
  parameter int W      = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_stall,
  input  logic                         i_valid,
  input  logic                         i_last,
  input  logic [N*W-1:0]               i_data,
  output logic [((N+1)/2)*(W+1)-1:0]   o_data,
  output logic                         o_valid,
  output logic                         o_last
);

  localparam int NO = (N + 1) / 2;

  logic r_valid;
  logic r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (!i_stall) begin
      r_valid <= i_valid;
      r_last  <= i_last;
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;

  for (genvar j = 0; j < NO; j++) begin : g_pair
    logic [W:0] w_a;
    logic [W:0] w_b;
    logic [W:0] r_sum;

    assign w_a = {SIGNED & i_data[2*j*W + W-1], i_data[2*j*W +: W]};

    // An odd leftover input passes through added to zero.
    if (2*j + 1 < N) begin : g_b
      assign w_b = {SIGNED & i_data[(2*j+1)*W + W-1], i_data[(2*j+1)*W +: W]};
    end else begin : g_zero
      assign w_b = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sum <= '0;
      end else if (!i_stall) begin
        r_sum <= w_a + w_b;
      end
    end

    assign o_data[j*(W+1) +: W+1] = r_sum;
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Multi-operand masked adder tree followed by a per-packet accumulator with
// sticky overflow, global stall and a one-cycle result strobe.
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int ADD_LENGTH = 16,
  parameter int SUM_LENGTH = 32,
  parameter int NUM_ADDEND = 45,
  parameter int SIGNED     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADD_LENGTH*NUM_ADDEND-1:0] addends,
  input  logic [NUM_ADDEND-1:0]            addend_en,
  input  logic                             in_valid,
  input  logic                             in_last,
  input  logic                             stall,
  output logic [SUM_LENGTH-1:0]            sum,
  output logic                             out_valid,
  output logic                             overflow,
  output logic                             busy
);

  localparam int STAGE_CNT = stage_cnt(NUM_ADDEND);
  localparam int PAD       = padded_cnt(NUM_ADDEND);
  localparam int TREE_W    = ADD_LENGTH + STAGE_CNT;
  localparam bit IS_SIGNED = (SIGNED != 0);

  if (NUM_ADDEND < 1) begin : g_err_num
    $error("adder_tree_acc: NUM_ADDEND must be at least 1");
  end
  if (SUM_LENGTH < TREE_W) begin : g_err_width
    $error("adder_tree_acc: SUM_LENGTH must be >= ADD_LENGTH + STAGE_CNT");
  end
  if (SUM_LENGTH > MAX_W) begin : g_err_max
    $error("adder_tree_acc: SUM_LENGTH exceeds package MAX_W");
  end

  logic [PAD*ADD_LENGTH-1:0] w_masked;
  logic [PAD*ADD_LENGTH-1:0] r_s0_data;
  logic                      r_s0_valid;
  logic                      r_s0_last;

  // Masked-off and padding slots enter the tree as zero.
  for (genvar i = 0; i < PAD; i++) begin : g_mask
    if (i < NUM_ADDEND) begin : g_real
      assign w_masked[i*ADD_LENGTH +: ADD_LENGTH] =
        addend_en[i] ? addends[i*ADD_LENGTH +: ADD_LENGTH] : '0;
    end else begin : g_pad
      assign w_masked[i*ADD_LENGTH +: ADD_LENGTH] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_data  <= '0;
      r_s0_valid <= 1'b0;
      r_s0_last  <= 1'b0;
    end else if (!stall) begin
      r_s0_data  <= w_masked;
      r_s0_valid <= in_valid;
      r_s0_last  <= in_valid & in_last;
    end
  end

  logic [TREE_W-1:0]  w_tree;
  logic               w_tree_valid;
  logic               w_tree_last;
  logic [STAGE_CNT:0] w_valid_vec;

  assign w_valid_vec[0] = r_s0_valid;

  if (STAGE_CNT == 0) begin : g_no_tree
    assign w_tree       = r_s0_data;
    assign w_tree_valid = r_s0_valid;
    assign w_tree_last  = r_s0_last;
  end else begin : g_tree
    for (genvar i = 1; i <= STAGE_CNT; i++) begin : g_lvl
      localparam int NIN = PAD >> (i - 1);
      localparam int WIN = ADD_LENGTH + i - 1;

      logic [NIN*WIN-1:0]           w_in;
      logic                         w_in_valid;
      logic                         w_in_last;
      logic [(NIN/2)*(WIN+1)-1:0]   w_out;
      logic                         w_out_valid;
      logic                         w_out_last;

      if (i == 1) begin : g_first
        assign w_in       = r_s0_data;
        assign w_in_valid = r_s0_valid;
        assign w_in_last  = r_s0_last;
      end else begin : g_next
        assign w_in       = g_lvl[i-1].w_out;
        assign w_in_valid = g_lvl[i-1].w_out_valid;
        assign w_in_last  = g_lvl[i-1].w_out_last;
      end

      adder_tree_level #(
        .N      (NIN),
        .W      (WIN),
        .SIGNED (IS_SIGNED)
      ) u_level (
        .clk     (clk),
        .rst     (rst),
        .i_stall (stall),
        .i_valid (w_in_valid),
        .i_last  (w_in_last),
        .i_data  (w_in),
        .o_data  (w_out),
        .o_valid (w_out_valid),
        .o_last  (w_out_last)
      );

      assign w_valid_vec[i] = w_out_valid;
    end

    assign w_tree       = g_lvl[STAGE_CNT].w_out;
    assign w_tree_valid = g_lvl[STAGE_CNT].w_out_valid;
    assign w_tree_last  = g_lvl[STAGE_CNT].w_out_last;
  end

  logic [SUM_LENGTH-1:0] w_tree_ext;
  logic [SUM_LENGTH-1:0] w_acc_next;
  logic                  w_carry;
  logic                  w_beat_ovf;

  for (genvar b = 0; b < SUM_LENGTH; b++) begin : g_ext
    assign w_tree_ext[b] = extend_bit(MAX_W'(w_tree), TREE_W, b, IS_SIGNED);
  end

  logic [SUM_LENGTH-1:0] r_acc;
  logic                  r_sticky;
  logic [SUM_LENGTH-1:0] r_sum;
  logic                  r_out_valid;
  logic                  r_overflow;

  assign {w_carry, w_acc_next} = {1'b0, r_acc} + {1'b0, w_tree_ext};
  assign w_beat_ovf = add_overflow(IS_SIGNED, r_acc[SUM_LENGTH-1],
                                   w_tree_ext[SUM_LENGTH-1],
                                   w_acc_next[SUM_LENGTH-1], w_carry);

  // A last beat publishes the total and restarts the packet from zero, so a
  // following beat in the very next cycle begins a fresh packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (!stall) begin
      r_out_valid <= 1'b0;
      if (w_tree_valid) begin
        if (w_tree_last) begin
          r_sum       <= w_acc_next;
          r_out_valid <= 1'b1;
          r_overflow  <= r_sticky | w_beat_ovf;
          r_acc       <= '0;
          r_sticky    <= 1'b0;
        end else begin
          r_acc    <= w_acc_next;
          r_sticky <= r_sticky | w_beat_ovf;
        end
      end
    end
  end

  assign sum       = r_sum;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign busy      = (|w_valid_vec) | (r_acc != '0);

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: three instances (unsigned 32-bit, signed
// 32-bit, unsigned 24-bit) share one stimulus stream.
module tb_adder_tree_acc;

  localparam int AW = 16;
  localparam int NA = 45;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW*NA-1:0] addends;
  logic [NA-1:0]    addendEn;
  logic             inValid;
  logic             inLast;
  logic             stall;

  logic [31:0] sumU, sumS;
  logic [23:0] sumN;
  logic        ovU, ovS, ovN;
  logic        ofU, ofS, ofN;
  logic        busyU, busyS, busyN;

  logic [31:0] gotSum  [3];
  logic        gotOv   [3];
  logic        gotOf   [3];
  logic        gotBusy [3];

  int nTotal = 0;
  int nBad   = 0;

  assign gotSum[0]  = sumU;
  assign gotSum[1]  = sumS;
  assign gotSum[2]  = {8'h00, sumN};
  assign gotOv[0]   = ovU;
  assign gotOv[1]   = ovS;
  assign gotOv[2]   = ovN;
  assign gotOf[0]   = ofU;
  assign gotOf[1]   = ofS;
  assign gotOf[2]   = ofN;
  assign gotBusy[0] = busyU;
  assign gotBusy[1] = busyS;
  assign gotBusy[2] = busyN;

  always #5 clk = ~clk;

  adder_tree_acc #(.ADD_LENGTH(16), .SUM_LENGTH(32), .NUM_ADDEND(45), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .addends(addends), .addend_en(addendEn),
    .in_valid(inValid), .in_last(inLast), .stall(stall),
    .sum(sumU), .out_valid(ovU), .overflow(ofU), .busy(busyU)
  );

  adder_tree_acc #(.ADD_LENGTH(16), .SUM_LENGTH(32), .NUM_ADDEND(45), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .addends(addends), .addend_en(addendEn),
    .in_valid(inValid), .in_last(inLast), .stall(stall),
    .sum(sumS), .out_valid(ovS), .overflow(ofS), .busy(busyS)
  );

  adder_tree_acc #(.ADD_LENGTH(16), .SUM_LENGTH(24), .NUM_ADDEND(45), .SIGNED(0)) u_dut_n (
    .clk(clk), .rst(rst), .addends(addends), .addend_en(addendEn),
    .in_valid(inValid), .in_last(inLast), .stall(stall),
    .sum(sumN), .out_valid(ovN), .overflow(ofN), .busy(busyN)
  );

  // Present one beat from a negedge; returns at the negedge after it is sampled.
  task automatic beat(input logic [15:0] val, input logic [NA-1:0] en, input logic last);
    addends  = {NA{val}};
    addendEn = en;
    inValid  = 1'b1;
    inLast   = last;
    @(negedge clk);
    inValid  = 1'b0;
    inLast   = 1'b0;
  endtask

  task automatic waitPulse(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ovU === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; inValid = 1'b1; inLast = 1'b1;
    addends = {NA{16'h0001}}; addendEn = '1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      nTotal++;
      if (gotSum[d] !== 32'd0 || gotOv[d] !== 1'b0 || gotOf[d] !== 1'b0 || gotBusy[d] !== 1'b0) begin
        nBad++;
        $display("[TB] FAIL reset_hold dut%0d: got sum=%0d ov=%b of=%b busy=%b expected all zero",
                 d, gotSum[d], gotOv[d], gotOf[d], gotBusy[d]);
      end
    end
    inValid = 1'b0; inLast = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      nTotal++;
      if (gotOv[d] !== 1'b0 || gotBusy[d] !== 1'b0) begin
        nBad++;
        $display("[TB] FAIL reset_release dut%0d: got ov=%b busy=%b expected 0 0", d, gotOv[d], gotBusy[d]);
      end
    end
  endtask

  task automatic test_single_beat();
    int c;
    beat(16'h0001, '1, 1'b1);
    waitPulse(c);
    nTotal++;
    if (c !== 7) begin nBad++; $display("[TB] FAIL single_latency: got %0d expected 7", c); end
    for (int d = 0; d < 3; d++) begin
      nTotal++;
      if (gotSum[d] !== 32'd45 || gotOv[d] !== 1'b1 || gotOf[d] !== 1'b0) begin
        nBad++;
        $display("[TB] FAIL single_sum dut%0d: got sum=%0d ov=%b of=%b expected 45 1 0",
                 d, gotSum[d], gotOv[d], gotOf[d]);
      end
    end
    @(negedge clk);
    nTotal++;
    if (ovU !== 1'b0 || ovS !== 1'b0 || ovN !== 1'b0) begin
      nBad++; $display("[TB] FAIL single_pulse_width: got ov=%b%b%b expected 000", ovU, ovS, ovN);
    end
  endtask

  task automatic test_multi_beat();
    int c;
    logic [31:0] exp [3];
    exp[0] = 32'd8847225; exp[1] = 32'hFFFFFF79; exp[2] = 32'd8847225;
    beat(16'hFFFF, '1, 1'b0);
    beat(16'hFFFF, '1, 1'b0);
    beat(16'hFFFF, '1, 1'b1);
    waitPulse(c);
    nTotal++;
    if (c !== 7) begin nBad++; $display("[TB] FAIL multi_latency: got %0d expected 7", c); end
    for (int d = 0; d < 3; d++) begin
      nTotal++;
      if (gotSum[d] !== exp[d] || gotOf[d] !== 1'b0) begin
        nBad++;
        $display("[TB] FAIL multi_sum dut%0d: got sum=%h of=%b expected %h 0", d, gotSum[d], gotOf[d], exp[d]);
      end
    end
  endtask

  task automatic test_signed();
    int c;
    logic [31:0] exp [3];
    exp[0] = 32'd1474560; exp[1] = 32'hFFE98000; exp[2] = 32'd1474560;
    beat(16'h8000, '1, 1'b1);
    waitPulse(c);
    nTotal++;
    if (c !== 7) begin nBad++; $display("[TB] FAIL signed_latency: got %0d expected 7", c); end
    for (int d = 0; d < 3; d++) begin
      nTotal++;
      if (gotSum[d] !== exp[d] || gotOf[d] !== 1'b0) begin
        nBad++;
        $display("[TB] FAIL signed_sum dut%0d: got sum=%h of=%b expected %h 0", d, gotSum[d], gotOf[d], exp[d]);
      end
    end
  endtask

  task automatic test_mask_stall();
    int c;
    int extra;
    logic [NA-1:0] evenOnly;
    for (int i = 0; i < NA; i++) evenOnly[i] = (i % 2 == 0);
    beat(16'h0001, evenOnly, 1'b1);
    repeat (2) @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    beat(16'hFFFF, '1, 1'b1);
    nTotal++;
    if (busyU !== 1'b1 || busyS !== 1'b1 || busyN !== 1'b1) begin
      nBad++; $display("[TB] FAIL stall_busy: got busy=%b%b%b expected 111", busyU, busyS, busyN);
    end
    repeat (2) @(negedge clk);
    stall = 1'b0;
    waitPulse(c);
    nTotal++;
    if (c !== 5) begin nBad++; $display("[TB] FAIL stall_latency: got %0d more cycles expected 5", c); end
    for (int d = 0; d < 3; d++) begin
      nTotal++;
      if (gotSum[d] !== 32'd23) begin
        nBad++; $display("[TB] FAIL mask_sum dut%0d: got %0d expected 23", d, gotSum[d]);
      end
    end
    stall = 1'b1;
    @(negedge clk);
    nTotal++;
    if (ovU !== 1'b1 || ovS !== 1'b1 || ovN !== 1'b1) begin
      nBad++; $display("[TB] FAIL stall_stretch: got ov=%b%b%b expected 111", ovU, ovS, ovN);
    end
    stall = 1'b0;
    @(negedge clk);
    nTotal++;
    if (ovU !== 1'b0) begin nBad++; $display("[TB] FAIL stall_release: got ov=%b expected 0", ovU); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (ovU === 1'b1) extra++;
    end
    nTotal++;
    if (extra !== 0) begin nBad++; $display("[TB] FAIL stall_drop: got %0d pulses expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int c;
    int seen;
    beat(16'h0001, '1, 1'b0);
    beat(16'h0001, '1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      nTotal++;
      if (gotBusy[d] !== 1'b0 || gotSum[d] !== 32'd0) begin
        nBad++;
        $display("[TB] FAIL midreset_clear dut%0d: got busy=%b sum=%0d expected 0 0", d, gotBusy[d], gotSum[d]);
      end
    end
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ovU === 1'b1) seen++;
    end
    nTotal++;
    if (seen !== 0) begin nBad++; $display("[TB] FAIL midreset_nopulse: got %0d pulses expected 0", seen); end
    beat(16'h0001, '1, 1'b1);
    waitPulse(c);
    nTotal++;
    if (c !== 7 || sumU !== 32'd45 || sumS !== 32'd45 || {8'h00, sumN} !== 32'd45) begin
      nBad++;
      $display("[TB] FAIL midreset_next: got lat=%0d sums=%0d/%0d/%0d expected 7 45/45/45", c, sumU, sumS, sumN);
    end
  endtask

  task automatic test_overflow(input logic stickyOnly);
    int c;
    logic [31:0] exp [3];
    logic        expOf [3];
    exp[0] = 32'd17694450; exp[1] = 32'hFFFFFEF2; exp[2] = 32'd917234;
    expOf[0] = 1'b0; expOf[1] = 1'b0; expOf[2] = 1'b1;
    repeat (5) beat(16'hFFFF, '1, 1'b0);
    if (stickyOnly) begin
      beat(16'hFFFF, '1, 1'b0);
      beat(16'hFFFF, '0, 1'b1);
    end else begin
      beat(16'hFFFF, '1, 1'b1);
    end
    waitPulse(c);
    nTotal++;
    if (c !== 7) begin nBad++; $display("[TB] FAIL ovf_latency: got %0d expected 7", c); end
    for (int d = 0; d < 3; d++) begin
      nTotal++;
      if (gotSum[d] !== exp[d] || gotOf[d] !== expOf[d]) begin
        nBad++;
        $display("[TB] FAIL ovf_sum sticky=%b dut%0d: got sum=%h of=%b expected %h %b",
                 stickyOnly, d, gotSum[d], gotOf[d], exp[d], expOf[d]);
      end
    end
    beat(16'h0001, '1, 1'b1);
    waitPulse(c);
    for (int d = 0; d < 3; d++) begin
      nTotal++;
      if (gotSum[d] !== 32'd45 || gotOf[d] !== 1'b0) begin
        nBad++;
        $display("[TB] FAIL ovf_next dut%0d: got sum=%0d of=%b expected 45 0", d, gotSum[d], gotOf[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    beat(16'h0001, '1, 1'b1);
    beat(16'h0002, '1, 1'b0);
    beat(16'h0002, '1, 1'b1);
    repeat (5) @(negedge clk);
    nTotal++;
    if (ovU !== 1'b1 || sumU !== 32'd45 || sumS !== 32'd45 || sumN !== 24'd45) begin
      nBad++;
      $display("[TB] FAIL b2b_first: got ov=%b sums=%0d/%0d/%0d expected 1 45/45/45", ovU, sumU, sumS, sumN);
    end
    @(negedge clk);
    nTotal++;
    if (ovU !== 1'b0) begin nBad++; $display("[TB] FAIL b2b_gap: got ov=%b expected 0", ovU); end
    @(negedge clk);
    nTotal++;
    if (ovU !== 1'b1 || sumU !== 32'd180 || sumS !== 32'd180 || sumN !== 24'd180) begin
      nBad++;
      $display("[TB] FAIL b2b_second: got ov=%b sums=%0d/%0d/%0d expected 1 180/180/180", ovU, sumU, sumS, sumN);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; inValid = 1'b0; inLast = 1'b0;
    addends = '0; addendEn = '0;
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_signed();
    test_mask_stall();
    test_reset_mid();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule

// File: doc/adder_tree_acc.md
# adder_tree_acc

Pipelined, parametrised multi-operand reduction tree with a packet accumulator, the next generation of `adder_tree`. Each valid beat carries `NUM_ADDEND` addends, with a runtime per-addend mask and selectable signed or unsigned arithmetic. The beat is reduced through one registered pairwise-add level per tree stage, then accumulated across a multi-beat packet. The block supports a global stall and a sticky overflow flag, and sits between operand-producing datapaths and the result consumer.

## Interface
- `ADD_LENGTH`, 16, width of each addend.
- `SUM_LENGTH`, 32, width of accumulator and `sum`.
- `NUM_ADDEND`, 45, addends per beat; must be ≥1.
- `SIGNED`, 0, 1 = two's-complement addends and sum, 0 = unsigned.
- `clk  in  1` rising-edge clock.
- `rst  in  1` asynchronous, active-low reset.
- `addends  in  ADD_LENGTH*NUM_ADDEND` packed addends; addend i = bits [i*ADD_LENGTH +: ADD_LENGTH].
- `addend_en  in  NUM_ADDEND` bit i = 0 → addend i treated as 0.
- `in_valid  in  1` beat present this cycle.
- `in_last  in  1` beat ends the packet; qualified by `in_valid`.
- `stall  in  1` freeze the entire block.
- `sum  out  SUM_LENGTH` packet total, held until the next packet completes.
- `out_valid  out  1` one-cycle pulse when `sum` updates.
- `overflow  out  1` packet overflowed; valid with `out_valid`, held with `sum`.
- `busy  out  1` any valid beat in the pipeline, or accumulator non-zero mid-packet.

## Operation
- STAGE_CNT = $clog2(NUM_ADDEND), which is 0 when NUM_ADDEND = 1.
- Elaboration error if SUM_LENGTH < ADD_LENGTH + STAGE_CNT.
- **Stage 0** registers the masked addends, zero-padded to 2^STAGE_CNT entries, together with `in_valid` and `in_last`.
- **Level i** (1..STAGE_CNT) registers pairwise sums of width ADD_LENGTH+i, extended per `SIGNED`. The tree itself never overflows.
- **Accumulate stage**: the tree result is sign- or zero-extended to SUM_LENGTH, then acc_next = acc + tree.
  - Beat without `in_last`: acc ← acc_next.
  - Beat with `in_last`: `sum` ← acc_next, `out_valid` ← 1, acc ← 0.
- **Overflow**
  - Unsigned: carry out of bit SUM_LENGTH-1.
  - Signed: operands have equal sign and the result sign differs.
  - Sticky across the packet. `overflow` is loaded with (sticky | this beat) on the last beat, then the sticky bit clears.
- Wrap-around: on overflow, `sum` is the result modulo 2^SUM_LENGTH.
- Stall high:
  - No register changes anywhere.
  - `in_valid` is ignored (the beat is dropped).
  - `out_valid` holds its value, so a pulse stretches for as long as stall is high.
- Invalid slots travel as bubbles and never touch acc.
- Reset (at any time, including mid-packet):
  - All valid bits, acc and sticky flag are cleared to 0.
  - `sum`=0, `out_valid`=0, `overflow`=0, `busy`=0.
  - In-flight beats are discarded.

## Timing
- Beat sampled at edge k → it reaches accumulate stage at edge k+STAGE_CNT+1.
- If `in_last`, `out_valid` is high in the cycle following that edge.
- LATENCY = STAGE_CNT+1 (7 for the defaults), plus one edge per stalled cycle.
- Throughput: one beat per unstalled cycle; back-to-back packets need no gap.
- An `in_last` beat followed immediately by a new packet's first beat: the new beat accumulates from 0.

## Structure
- **Package `adder_tree_pkg`** contains:
  - `stage_cnt(n)` function.
  - Padded-width function.
  - Signed/unsigned extend function.
  - Overflow-detect function.
- **Sub-module `adder_tree_level`**, parameters N inputs, width W, SIGNED.
  - Registered ceil(N/2) sums of width W+1, plus valid/last, honouring `stall` and `rst`.
  - Instantiated STAGE_CNT times via generate.
- **Top level** holds: the mask and stage-0 register, the accumulator, the sticky flag and the output registers.

## Test plan
- **Reset**: hold `rst` low 3 cycles, with `in_valid` high during reset → `sum`=0, `out_valid`=0, `overflow`=0, `busy`=0.
- **Single beat** (defaults): all addends 1, mask all ones, `in_last`=1, sampled at edge k → single `out_valid` pulse after edge k+7, `sum`=45.
- **Multi-beat, unsigned**: 3 beats, all addends 16'hFFFF, `in_last` on beat 3 only → one pulse, `sum`=8847225; `overflow`=0.
- **Signed**: SIGNED=1, one beat, all addends 16'h8000 → `sum`=32'hFFE98000 (−1474560), `overflow`=0.
- **Mask and stall**:
  - Stimulus: odd-index addends masked, all addends 1; `stall` high 4 cycles while the beat is mid-tree.
  - Response: `sum`=23, pulse after edge k+11.
  - Stimulus: `rst` pulsed mid-packet.
  - Response: no pulse; the next packet's sum excludes pre-reset beats.
- **Overflow**: SUM_LENGTH=24, unsigned, 6 beats of all-16'hFFFF → `overflow`=1, `sum`=917234; the next packet (1 beat of ones) → `overflow`=0, `sum`=45.
